// File: rtl/fact_engine_arbiter_pkg.sv
// Shared definitions for the two-requester factorial engine arbiter:
// FSM state encodings, requester count and the grant-to-ack helper.
package fact_engine_arbiter_pkg;

    localparam int REQ_N = 2;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LAUNCH  = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_RECOVER = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    function automatic logic [REQ_N-1:0] idx_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fact_engine_arbiter_if.sv
// Requester-side bus of the arbiter: request levels and operands in,
// per-requester ack pulse and the shared response fields out.
interface fact_engine_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    import fact_engine_arbiter_pkg::*;

    logic [REQ_N-1:0]      req;
    logic [DATA_WIDTH-1:0] op0;
    logic [DATA_WIDTH-1:0] op1;
    logic [REQ_N-1:0]      ack;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;
    logic                  rsp_timeout;

    modport master (
        output req, op0, op1,
        input  ack, rsp_data, rsp_err, rsp_timeout
    );

    modport slave (
        input  req, op0, op1,
        output ack, rsp_data, rsp_err, rsp_timeout
    );

endinterface

// File: rtl/fact_engine_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone request always wins, contention goes
// to the requester that was not served last. Purely combinational.
module rr_arb2
    import fact_engine_arbiter_pkg::*;
(
    input  logic [REQ_N-1:0] i_req,
    input  logic             i_last_grant,
    output logic             o_gnt_idx,
    output logic             o_gnt_valid
);

    always_comb begin
        // NOTE: default assignment first so no path leaves the output unassigned (no latch).
        o_gnt_idx = 1'b0;
        case (i_req)
            2'b10:   o_gnt_idx = 1'b1;
            2'b11:   o_gnt_idx = ~i_last_grant;
            default: o_gnt_idx = 1'b0;
        endcase
    end

    assign o_gnt_valid = |i_req;

endmodule

// File: rtl/fact_engine_arbiter.sv
// Shares one factorial engine between two requesters: round-robin grant,
// GO/DONE sequencing, result capture, one-cycle ack and timeout recovery.
module fact_engine_arbiter
    import fact_engine_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    fact_engine_arbiter_if.slave  bus,
    output logic                  o_busy,
    output logic                  o_eng_go,
    output logic                  o_eng_rst,
    output logic [DATA_WIDTH-1:0] o_eng_d,
    input  logic                  i_eng_done,
    input  logic                  i_eng_error,
    input  logic [DATA_WIDTH-1:0] i_eng_result
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int RW = $clog2(RECOVER_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RC_LAST = RW'(RECOVER_CYCLES - 1);

    logic [2:0]            r_state;
    logic                  r_grant;
    logic                  r_last_grant;
    logic                  r_eng_go;
    logic [DATA_WIDTH-1:0] r_eng_d;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;
    logic [TW-1:0]         r_to_cnt;
    logic [RW-1:0]         r_rec_cnt;
    logic                  w_gnt_idx;
    logic                  w_gnt_valid;

    rr_arb2 u_rr_arb2 (
        .i_req        (bus.req),
        .i_last_grant (r_last_grant),
        .o_gnt_idx    (w_gnt_idx),
        .o_gnt_valid  (w_gnt_valid)
    );

    // NOTE: reset is synchronous, so it lives inside the clocked block; state uses <= only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_grant       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_eng_go      <= 1'b0;
            r_eng_d       <= '0;
            r_rsp_data    <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_to_cnt      <= '0;
            r_rec_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_grant <= w_gnt_idx;
                        r_eng_d <= w_gnt_idx ? bus.op1 : bus.op0;
                        r_state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_eng_go <= 1'b1;
                    r_to_cnt <= '0;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_eng_done) begin
                        r_eng_go      <= 1'b0;
                        r_rsp_err     <= i_eng_error;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_data    <= i_eng_error ? '0 : i_eng_result;
                        r_state       <= ST_RESP;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_eng_go  <= 1'b0;
                        r_rec_cnt <= '0;
                        r_state   <= ST_RECOVER;
                    end else if (r_to_cnt != '1) begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end
                end
                ST_RECOVER: begin
                    // Engine is held in reset here; the aborted job is answered as a timeout.
                    if (r_rec_cnt == RC_LAST) begin
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_data    <= '0;
                        r_state       <= ST_RESP;
                    end else begin
                        r_rec_cnt <= r_rec_cnt + RW'(1);
                    end
                end
                ST_RESP: begin
                    r_last_grant <= r_grant;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ack         = (r_state == ST_RESP) ? idx_onehot(r_grant) : '0;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign o_busy          = (r_state != ST_IDLE);
    assign o_eng_go        = r_eng_go;
    assign o_eng_d         = r_eng_d;
    assign o_eng_rst       = i_rst | (r_state == ST_RECOVER);

endmodule

// File: tb/tb_fact_engine_arbiter.sv
// Self-checking bench for fact_engine_arbiter: a behavioural factorial engine
// plus a reference model of grant order, results and handshake timing.
module tb_fact_engine_arbiter;

    localparam int DW = 32;
    localparam int TO = 16;
    localparam int RC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fact_engine_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    logic          busy;
    logic          eng_go;
    logic          eng_rst;
    logic [DW-1:0] eng_d;
    logic          eng_done   = 1'b0;
    logic          eng_error  = 1'b0;
    logic [DW-1:0] eng_result = '0;

    fact_engine_arbiter #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO),
        .RECOVER_CYCLES (RC)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .bus          (bus),
        .o_busy       (busy),
        .o_eng_go     (eng_go),
        .o_eng_rst    (eng_rst),
        .o_eng_d      (eng_d),
        .i_eng_done   (eng_done),
        .i_eng_error  (eng_error),
        .i_eng_result (eng_result)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    // Reference: n! with 32-bit overflow reported as {err, data}.
    function automatic logic [DW:0] ref_fact(input logic [DW-1:0] n);
        longint unsigned p;
        p = 1;
        for (longint unsigned k = 2; k <= 64'(n); k++) begin
            p = p * k;
            if (p > 64'hFFFF_FFFF) return {1'b1, 32'h0};
        end
        return {1'b0, p[31:0]};
    endfunction

    // Behavioural engine: latches eng_d on GO, answers after a random delay,
    // waits for GO to drop, can hang, and can emit a stray DONE on request.
    bit            hang       = 1'b0;
    int            lat_base   = 0;
    int            stray_cnt  = 0;
    int            stray_seen = 0;
    bit            e_busy     = 1'b0;
    bit            e_wait_low = 1'b0;
    int            e_cnt      = 0;
    logic [DW-1:0] e_op       = '0;
    int            last_done_cyc = 0;

    always @(negedge clk) begin
        logic [DW:0] fr;
        eng_done  = 1'b0;
        eng_error = 1'b0;
        if (eng_rst) begin
            e_busy     = 1'b0;
            e_wait_low = 1'b0;
        end else if (stray_cnt != stray_seen) begin
            stray_seen = stray_cnt;
            eng_done   = 1'b1;
            eng_result = 32'h0000_1234;
        end else if (e_wait_low) begin
            if (!eng_go) e_wait_low = 1'b0;
        end else if (e_busy) begin
            if (e_cnt > 0) begin
                e_cnt--;
            end else if (!hang) begin
                fr            = ref_fact(e_op);
                eng_error     = fr[DW];
                eng_result    = fr[DW] ? 32'hDEAD_0000 : fr[DW-1:0];
                eng_done      = 1'b1;
                e_busy        = 1'b0;
                e_wait_low    = 1'b1;
                last_done_cyc = cyc;
            end
        end else if (eng_go) begin
            e_busy = 1'b1;
            e_op   = eng_d;
            e_cnt  = lat_base + int'($urandom_range(0, 3));
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic m_last = 1'b1;

    // Waits (bounded) for the next ack and checks it against the model.
    task automatic expect_ack(input logic idx, input logic [DW:0] exp_fr, input logic exp_to,
                              input bit chk_lat, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.ack == 2'b00 && n < 200);
        check({tag, "_ack"}, 64'(bus.ack), idx ? 64'd2 : 64'd1);
        check({tag, "_data"}, 64'(bus.rsp_data), exp_fr[DW] ? 64'd0 : 64'(exp_fr[DW-1:0]));
        check({tag, "_err"}, 64'(bus.rsp_err), 64'(exp_fr[DW]));
        check({tag, "_tmo"}, 64'(bus.rsp_timeout), 64'(exp_to));
        if (chk_lat) check({tag, "_lat"}, 64'(cyc), 64'(last_done_cyc + 1));
        m_last = idx;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.req = '0;
        bus.op0 = '0;
        bus.op1 = '0;

        // Reset values
        rst = 1'b1;
        tick();
        check("rst_ack", 64'(bus.ack), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_go", 64'(eng_go), 0);
        check("rst_eng_d", 64'(eng_d), 0);
        check("rst_data", 64'(bus.rsp_data), 0);
        check("rst_err", 64'(bus.rsp_err), 0);
        check("rst_tmo", 64'(bus.rsp_timeout), 0);
        check("rst_eng_rst", 64'(eng_rst), 1);
        rst = 1'b0;
        tick();
        check("post_rst_eng_rst", 64'(eng_rst), 0);

        // 1: single request, GO latency, result and busy release
        bus.op0 = 32'd5;
        bus.req = 2'b01;
        tick();
        check("t1_launch_go", 64'(eng_go), 0);
        check("t1_busy", 64'(busy), 1);
        check("t1_eng_d", 64'(eng_d), 5);
        tick();
        check("t1_go_t2", 64'(eng_go), 1);
        expect_ack(1'b0, ref_fact(32'd5), 1'b0, 1'b1, "t1");
        bus.req = 2'b00;
        tick();
        check("t1_busy_low", 64'(busy), 0);
        check("t1_ack_low", 64'(bus.ack), 0);
        check("t1_hold", 64'(bus.rsp_data), 120);

        // 2: contention from reset, strict alternation while both hold req
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_last = 1'b1;
        bus.op0 = 32'd4;
        bus.op1 = 32'd6;
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            logic g;
            g = ~m_last;
            expect_ack(g, ref_fact(g ? bus.op1 : bus.op0), 1'b0, 1'b1, "t2");
        end
        bus.req = 2'b00;
        tick();

        // 3: overflow reported by the engine
        bus.op1 = 32'd13;
        bus.req = 2'b10;
        expect_ack(1'b1, ref_fact(32'd13), 1'b0, 1'b1, "t3");
        bus.req = 2'b00;
        tick();

        // 4: hung engine -> timeout, recovery reset, timeout response
        hang = 1'b1;
        bus.op0 = 32'd3;
        bus.req = 2'b01;
        tick();
        tick();
        n = 0;
        while (eng_go === 1'b1 && n < 64) begin
            n++;
            tick();
        end
        check("t4_wait_cycles", 64'(n), 64'(TO));
        check("t4_rst_a", 64'(eng_rst), 1);
        tick();
        check("t4_rst_b", 64'(eng_rst), 1);
        check("t4_no_early_ack", 64'(bus.ack), 0);
        expect_ack(1'b0, {1'b1, 32'h0}, 1'b1, 1'b0, "t4");
        check("t4_rst_release", 64'(eng_rst), 0);
        hang = 1'b0;
        bus.req = 2'b00;
        tick();

        // 5: reset in the middle of WAIT drops the job
        hang = 1'b1;
        bus.op0 = 32'd9;
        bus.req = 2'b01;
        tick();
        tick();
        tick();
        tick();
        check("t5_in_wait", 64'(eng_go), 1);
        rst = 1'b1;
        bus.req = 2'b00;
        tick();
        check("t5_ack", 64'(bus.ack), 0);
        check("t5_busy", 64'(busy), 0);
        check("t5_go", 64'(eng_go), 0);
        check("t5_eng_d", 64'(eng_d), 0);
        check("t5_data", 64'(bus.rsp_data), 0);
        check("t5_err", 64'(bus.rsp_err), 0);
        check("t5_tmo", 64'(bus.rsp_timeout), 0);
        rst = 1'b0;
        hang = 1'b0;
        m_last = 1'b1;
        tick();
        check("t5_no_ack", 64'(bus.ack), 0);
        bus.op0 = 32'd12;
        bus.req = 2'b01;
        expect_ack(1'b0, ref_fact(32'd12), 1'b0, 1'b1, "t5");
        bus.req = 2'b00;
        tick();

        // 6: operand changes after grant and a stray DONE while idle
        lat_base = 4;
        bus.op0 = 32'd8;
        bus.req = 2'b01;
        tick();
        tick();
        tick();
        bus.op0 = 32'd7;
        tick();
        check("t6_eng_d_latched", 64'(eng_d), 8);
        expect_ack(1'b0, ref_fact(32'd8), 1'b0, 1'b1, "t6");
        bus.req = 2'b00;
        lat_base = 0;
        tick();
        stray_cnt++;
        tick();
        tick();
        check("t6_stray_ack", 64'(bus.ack), 0);
        check("t6_stray_busy", 64'(busy), 0);
        check("t6_stray_hold", 64'(bus.rsp_data), 40320);

        // Randomized jobs: each served requester drops its request at its ack
        for (int it = 0; it < 24; it++) begin
            logic [1:0]    r;
            logic [DW-1:0] a;
            logic [DW-1:0] b;
            logic          g;
            r = 2'($urandom_range(1, 3));
            a = 32'($urandom_range(0, 14));
            b = 32'($urandom_range(0, 14));
            lat_base = int'($urandom_range(0, 5));
            bus.op0 = a;
            bus.op1 = b;
            bus.req = r;
            while (bus.req != 2'b00) begin
                g = (bus.req == 2'b11) ? ~m_last : bus.req[1];
                expect_ack(g, ref_fact(g ? b : a), 1'b0, 1'b1, "rnd");
                bus.req[g] = 1'b0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
